// File: rtl/tmboc_pkg.sv
// Shared types and register map for the design-slot switch controller.
// Holds the FSM state encoding, register offsets, STATUS bit positions and a byte-lane merge helper.
package tmboc_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD_A = 2'd1,
    ST_SWAP   = 2'd2,
    ST_HOLD_B = 2'd3
  } state_e;

  // Word offsets, i.e. wbs_adr_i[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_CLKDIV = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_ERR_BIT  = 1;
  localparam int unsigned STATUS_SEL_LSB  = 8;

  localparam int unsigned CLKDIV_W = 16;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/design_clk_div.sv
// Divided design clock: toggles every div_i+1 cycles; clr_i restarts it from a low phase.
module design_clk_div #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tgl_q, tgl_d;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    tgl_d = tgl_q;
    if (clr_i) begin
      cnt_d = '0;
      tgl_d = 1'b0;
    end else if (cnt_q == div_i) begin
      cnt_d = '0;
      tgl_d = ~tgl_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tgl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tgl_q <= tgl_d;
    end
  end

  assign clk_o = tgl_q;

endmodule

// File: rtl/design_switch_ctrl.sv
// Wishbone-configured owner of the shared design slot: active index, glitch-safe
// reset/swap/release sequence and the divided design clock.
module design_switch_ctrl
  import tmboc_pkg::*;
#(
  parameter int unsigned NUM_DESIGNS = 16,
  parameter int unsigned SEL_W       = 5,
  parameter int unsigned RST_HOLD    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic [31:0]            wbs_dat_o,
  output logic                   wbs_ack_o,
  output logic [NUM_DESIGNS-1:0] rst_o,
  output logic [SEL_W-1:0]       active_sel_o,
  output logic                   design_clk_o,
  output logic                   busy_o
);

  localparam int unsigned       CNT_W     = $clog2(RST_HOLD + 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RST_HOLD - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       target_q, target_d;
  logic [SEL_W-1:0]       active_q, active_d;
  logic                   pending_q, pending_d;
  logic                   err_q, err_d;
  logic [CLKDIV_W-1:0]    clkdiv_q, clkdiv_d;
  logic [NUM_DESIGNS-1:0] rst_q, rst_d;
  logic                   ack_q, ack_d;
  logic [31:0]            dat_q, dat_d;

  logic        hit, req, wr, ctrl_wr, div_wr, ctrl_ok, start;
  logic [1:0]  off;
  logic [31:0] ctrl_val, rdata, status;
  logic [1:0]  unused_adr;

  assign unused_adr = wbs_adr_i[1:0];

  assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req     = wbs_cyc_i && wbs_stb_i && hit && !ack_q;
  assign wr      = req && wbs_we_i;
  assign off     = wbs_adr_i[3:2];
  assign ctrl_wr = wr && (off == REG_CTRL) && (|wbs_sel_i);
  assign div_wr  = wr && (off == REG_CLKDIV) && (|wbs_sel_i);

  // Unwritten lanes keep the current target, so out-of-range detection sees the merged word
  assign ctrl_val = merge_lanes(32'(target_q), wbs_dat_i, wbs_sel_i);
  assign ctrl_ok  = (ctrl_val < NUM_DESIGNS);
  assign start    = ctrl_wr && ctrl_ok;

  always_comb begin
    status                               = '0;
    status[STATUS_BUSY_BIT]              = (state_q != ST_RUN);
    status[STATUS_ERR_BIT]               = err_q;
    status[STATUS_SEL_LSB +: SEL_W]      = active_q;
  end

  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL:   rdata = 32'(target_q);
      REG_CLKDIV: rdata = 32'(clkdiv_q);
      REG_STATUS: rdata = status;
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    ack_d    = req;
    dat_d    = (req && !wbs_we_i) ? rdata : '0;
    clkdiv_d = clkdiv_q;
    if (div_wr) begin
      if (wbs_sel_i[0]) clkdiv_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) clkdiv_d[15:8] = wbs_dat_i[15:8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    active_d  = active_q;
    pending_d = pending_q;
    err_d     = err_q;

    if (start) begin
      target_d = ctrl_val[SEL_W-1:0];
      err_d    = 1'b0;
    end else if (ctrl_wr) begin
      err_d    = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (start) begin
          state_d = ST_HOLD_A;
          cnt_d   = '0;
        end
      end
      ST_HOLD_A: begin
        if (start) pending_d = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_SWAP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_SWAP: begin
        if (start) pending_d = 1'b1;
        active_d = target_d;
        state_d  = ST_HOLD_B;
        cnt_d    = '0;
      end
      ST_HOLD_B: begin
        if (start) pending_d = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          // A write landing on the exit edge folds into the pending re-run
          if (pending_q || start) begin
            state_d   = ST_HOLD_A;
            pending_d = 1'b0;
          end else begin
            state_d   = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_HOLD_B;
        cnt_d   = '0;
      end
    endcase

    for (int unsigned i = 0; i < NUM_DESIGNS; i++) begin
      rst_d[i] = (state_d != ST_RUN) || (active_d != SEL_W'(i));
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_HOLD_B;
      cnt_q     <= '0;
      target_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      clkdiv_q  <= '0;
      rst_q     <= '1;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      clkdiv_q  <= clkdiv_d;
      rst_q     <= rst_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  design_clk_div #(
    .DIV_W (CLKDIV_W)
  ) u_clk_div (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .clr_i (div_wr),
    .div_i (clkdiv_q),
    .clk_o (design_clk_o)
  );

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign rst_o        = rst_q;
  assign active_sel_o = active_q;
  assign busy_o       = (state_q != ST_RUN);

endmodule

// File: tb/tb_design_switch_ctrl.sv
// Directed bench for design_switch_ctrl with hand-computed expectations (RST_HOLD=8, 16 designs).
module tb_design_switch_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic [31:0] rdat;
  logic        ack;
  logic [15:0] rst_o;
  logic [4:0]  active;
  logic        dclk;
  logic        busy;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic        rel_seen = 1'b0;

  always #5 clk = ~clk;

  design_switch_ctrl #(
    .NUM_DESIGNS (16),
    .SEL_W       (5),
    .RST_HOLD    (8),
    .BASE_ADDR   (BASE)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (wdat),
    .wbs_dat_o    (rdat),
    .wbs_ack_o    (ack),
    .rst_o        (rst_o),
    .active_sel_o (active),
    .design_clk_o (dclk),
    .busy_o       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_o != 16'hFFFF) rel_seen = 1'b1;
  endtask

  task automatic tickn(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic got;
    got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      got = ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    chk("wr_ack", 32'(got), 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    logic got;
    got = 1'b0;
    d   = 32'hDEAD_BEEF;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      got = ack;
      if (got) d = rdat;
    end
    cyc = 1'b0; stb = 1'b0; sel = 4'h0;
    chk("rd_ack", 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      done = !busy;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    logic        ack_seen;

    // Reset values
    tickn(3);
    chk("rst_ack",    32'(ack),    32'd0);
    chk("rst_dat",    rdat,        32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_rsto",   32'(rst_o),  32'h0000_FFFF);
    chk("rst_dclk",   32'(dclk),   32'd0);
    chk("rst_busy",   32'(busy),   32'd1);
    rst = 1'b0;
    tickn(7);
    chk("boot_hold",  32'(rst_o),  32'h0000_FFFF);
    tick();
    chk("boot_rel",   32'(rst_o),  32'h0000_FFFE);
    chk("boot_busy",  32'(busy),   32'd0);

    // Switch to design 3
    wb_write(BASE + 32'h0, 32'd3, 4'hF);
    chk("sw3_busy",   32'(busy),   32'd1);
    chk("sw3_rsto",   32'(rst_o),  32'h0000_FFFF);
    tickn(8);
    chk("sw3_pre",    32'(active), 32'd0);
    tick();
    chk("sw3_swap",   32'(active), 32'd3);
    tickn(7);
    chk("sw3_hold",   32'(rst_o),  32'h0000_FFFF);
    chk("sw3_bsy16",  32'(busy),   32'd1);
    tick();
    chk("sw3_rel",    32'(rst_o),  32'h0000_FFF7);
    chk("sw3_idle",   32'(busy),   32'd0);

    // Pending re-run: 1, then 5 in HOLD_A, then 7 in HOLD_B
    wb_write(BASE + 32'h0, 32'd1, 4'hF);
    rel_seen = 1'b0;
    tickn(2);
    wb_write(BASE + 32'h0, 32'd5, 4'hF);
    chk("pend_busy",  32'(busy),   32'd1);
    tickn(10);
    wb_write(BASE + 32'h0, 32'd7, 4'hF);
    chk("pend_act5",  32'(active), 32'd5);
    tickn(3);
    chk("pend_rerun", 32'(busy),   32'd1);
    chk("pend_rsto",  32'(rst_o),  32'h0000_FFFF);
    tickn(16);
    chk("pend_norel", 32'(rel_seen), 32'd0);
    chk("pend_bsy",   32'(busy),   32'd1);
    tick();
    chk("pend_rel7",  32'(rst_o),  32'h0000_FF7F);
    chk("pend_act7",  32'(active), 32'd7);
    chk("pend_idle",  32'(busy),   32'd0);

    // Out-of-range index
    wb_write(BASE + 32'h0, 32'd20, 4'hF);
    chk("oor_nobusy", 32'(busy),   32'd0);
    wb_read(BASE + 32'h8, v);
    chk("oor_status", v,           32'h0000_0702);
    wb_read(BASE + 32'h0, v);
    chk("oor_target", v,           32'd7);
    wb_write(BASE + 32'h0, 32'd2, 4'hF);
    wb_read(BASE + 32'h8, v);
    chk("err_clr",    v,           32'h0000_0701);
    wait_idle("sw2_done");
    chk("sw2_act",    32'(active), 32'd2);
    chk("sw2_rsto",   32'(rst_o),  32'h0000_FFFB);

    // Clock divider, period 6, kept running through a switch
    wb_write(BASE + 32'h4, 32'd2, 4'hF);
    chk("div_k0",     32'(dclk),   32'd0);
    for (int unsigned k = 1; k < 12; k++) begin
      tick();
      chk("div_pat",  32'(dclk),   32'((k / 3) % 2));
    end
    wb_write(BASE + 32'h0, 32'd4, 4'hF);
    chk("div_k12",    32'(dclk),   32'd0);
    for (int unsigned k = 13; k < 31; k++) begin
      tick();
      chk("div_sw",   32'(dclk),   32'((k / 3) % 2));
    end
    wait_idle("sw4_done");
    chk("sw4_act",    32'(active), 32'd4);

    // Reset during HOLD_B
    wb_write(BASE + 32'h0, 32'd6, 4'hF);
    tickn(12);
    rst = 1'b1;
    tick();
    chk("mid_rsto",   32'(rst_o),  32'h0000_FFFF);
    chk("mid_act",    32'(active), 32'd0);
    chk("mid_dclk",   32'(dclk),   32'd0);
    chk("mid_ack",    32'(ack),    32'd0);
    rst = 1'b0;
    wb_read(BASE + 32'h4, v);
    chk("mid_div",    v,           32'd0);
    wb_read(BASE + 32'hC, v);
    chk("rsvd_rd",    v,           32'd0);

    // Byte lanes on CLKDIV
    wb_write(BASE + 32'h4, 32'h0000_AB05, 4'b0001);
    wb_read(BASE + 32'h4, v);
    chk("lane_div",   v,           32'h0000_0005);

    // Held strobe acks every other cycle
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'hC; sel = 4'hF;
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      chk("held_ack", 32'(ack),    32'((k + 1) % 2));
      if (!ack) chk("held_dat0", rdat, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    tick();

    // Off-base address never acked
    ack_seen = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h10; wdat = 32'd1; sel = 4'hF;
    for (int unsigned k = 0; k < 5; k++) begin
      tick();
      if (ack) ack_seen = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("miss_noack", 32'(ack_seen), 32'd0);
    wb_read(BASE + 32'h0, v);
    chk("miss_ctrl",  v,           32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
